// File: rtl/text_overlay_engine.sv
// Text row overlay: N_CHARS glyphs from a double-buffered char RAM, scaled, coloured, optionally blinking.
// Ports: Clk/Reset (sync, active-low), frame_start, DrawX/DrawY, wr_*/swap_req (back-bank update), swap_pending,
// font_addr/font_data (external sync font ROM), text_on, Red/Green/Blue. Optional macro: TEXT_OVERLAY_BLINK_EN.
module text_overlay_engine #(
  parameter int N_CHARS      = 16,
  parameter int ORIGIN_X     = 230,
  parameter int ORIGIN_Y     = 80,
  parameter int SCALE_LOG2   = 0,
  parameter int CHAR_PITCH   = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_start,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       wr_en,
  input  logic [$clog2(N_CHARS)-1:0] wr_addr,
  input  logic [7:0]                 wr_char,
  input  logic [2:0]                 wr_attr,
  input  logic                       swap_req,
  output logic                       swap_pending,
  output logic [10:0]                font_addr,
  input  logic [7:0]                 font_data,
  output logic                       text_on,
  output logic [7:0]                 Red,
  output logic [7:0]                 Green,
  output logic [7:0]                 Blue
);

  localparam int AW = $clog2(N_CHARS);
  localparam int GW = 8 << SCALE_LOG2;
  localparam int GH = 16 << SCALE_LOG2;
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + GH);
  localparam logic [10:0] W11  = 11'(GW);

  logic       active;
  logic [7:0] chr_q [2][N_CHARS];
  logic [2:0] atr_q [2][N_CHARS];

  // Writes always land in the bank not being displayed.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_CHARS; i++) begin
          chr_q[b][i] <= '0;
          atr_q[b][i] <= '0;
        end
      end
    end else if (wr_en && (32'(wr_addr) < N_CHARS)) begin
      chr_q[~active][wr_addr] <= wr_char;
      atr_q[~active][wr_addr] <= wr_attr;
    end
  end

  // A pending swap is only taken at a frame boundary.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      active       <= 1'b0;
      swap_pending <= 1'b0;
    end else if (frame_start && swap_pending) begin
      active       <= ~active;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

  logic [10:0]   dx;
  logic [10:0]   dy;
  logic [10:0]   dxo;
  logic [10:0]   dyo;
  logic [10:0]   sx;
  logic          y_in;
  logic          hit_d;
  logic [AW-1:0] slot_d;
  logic [2:0]    col_d;
  logic [3:0]    row_d;

  // Slots never overlap, so at most one comparator fires.
  always_comb begin
    dx     = {1'b0, DrawX};
    dy     = {1'b0, DrawY};
    dyo    = dy - Y_LO;
    y_in   = (dy >= Y_LO) && (dy < Y_HI);
    row_d  = 4'(dyo >> SCALE_LOG2);
    hit_d  = 1'b0;
    slot_d = '0;
    sx     = '0;
    dxo    = '0;
    for (int i = 0; i < N_CHARS; i++) begin
      sx = 11'(ORIGIN_X + i * CHAR_PITCH);
      if (y_in && (dx >= sx) && (dx < sx + W11)) begin
        hit_d  = 1'b1;
        slot_d = AW'(i);
        dxo    = dx - sx;
      end
    end
    col_d = 3'(dxo >> SCALE_LOG2);
  end

  logic [7:0] rd_chr;
  logic [2:0] rd_atr;

  assign rd_chr = chr_q[active][slot_d];
  assign rd_atr = atr_q[active][slot_d];

  logic       s1_hit;
  logic       s1_nz;
  logic [2:0] s1_col;
  logic [2:0] s1_attr;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s1_hit    <= 1'b0;
      s1_nz     <= 1'b0;
      s1_col    <= '0;
      s1_attr   <= '0;
      font_addr <= '0;
    end else begin
      s1_hit    <= hit_d;
      s1_nz     <= hit_d && (rd_chr != 8'h00);
      s1_col    <= col_d;
      s1_attr   <= hit_d ? rd_atr : 3'd0;
      font_addr <= hit_d ? {rd_chr[6:0], row_d} : 11'd0;
    end
  end

  // Holds the pixel context while the font ROM read is in flight.
  logic       s2_hit;
  logic       s2_nz;
  logic [2:0] s2_col;
  logic [2:0] s2_attr;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      s2_hit  <= 1'b0;
      s2_nz   <= 1'b0;
      s2_col  <= '0;
      s2_attr <= '0;
    end else begin
      s2_hit  <= s1_hit;
      s2_nz   <= s1_nz;
      s2_col  <= s1_col;
      s2_attr <= s1_attr;
    end
  end

  logic blink_hide;

`ifdef TEXT_OVERLAY_BLINK_EN
  logic [5:0] blink_cnt;
  logic       blink_phase;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == 6'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 6'd1;
      end
    end
  end

  assign blink_hide = s2_attr[2] & blink_phase;
`else
  logic unused_blink_attr;

  assign unused_blink_attr = s2_attr[2];
  assign blink_hide        = 1'b0;
`endif

  function automatic logic [23:0] palette(input logic [1:0] idx);
    logic [23:0] c;
    unique case (idx)
      2'd0:    c = 24'hFFFF00;
      2'd1:    c = 24'hFFFFFF;
      2'd2:    c = 24'hFF0000;
      default: c = 24'h00FFFF;
    endcase
    return c;
  endfunction

  logic lit;

  assign lit = s2_hit && s2_nz && font_data[3'd7 - s2_col] && !blink_hide;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      text_on <= 1'b0;
      Red     <= '0;
      Green   <= '0;
      Blue    <= '0;
    end else begin
      text_on <= lit;
      {Red, Green, Blue} <= lit ? palette(s2_attr[1:0]) : 24'd0;
    end
  end

endmodule

// File: tb/tb_text_overlay_engine.sv
// Bench for text_overlay_engine: two instances (scale 1x and 2x) against a behavioural model.
// Ports: all DUT ports driven/observed; font ROM modelled as a registered array.
module tb_text_overlay_engine;

  localparam int N  = 16;
  localparam int OX = 230;
  localparam int OY = 80;
  localparam int PA = 10;
  localparam int PB = 20;
  localparam int BF = 2;
  localparam int NS = 150;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_start;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_char;
  logic [2:0] wr_attr;
  logic       swap_req;

  logic        so_a, so_b;
  logic [10:0] fa_a, fa_b;
  logic [7:0]  fd_a, fd_b;
  logic        on_a, on_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  always #5 Clk = ~Clk;

  text_overlay_engine #(.BLINK_FRAMES(BF)) dut_a (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_char(wr_char), .wr_attr(wr_attr), .swap_req(swap_req),
    .swap_pending(so_a), .font_addr(fa_a), .font_data(fd_a),
    .text_on(on_a), .Red(r_a), .Green(g_a), .Blue(b_a)
  );

  text_overlay_engine #(
    .SCALE_LOG2(1), .CHAR_PITCH(PB), .BLINK_FRAMES(BF)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_char(wr_char), .wr_attr(wr_attr), .swap_req(swap_req),
    .swap_pending(so_b), .font_addr(fa_b), .font_data(fd_b),
    .text_on(on_b), .Red(r_b), .Green(g_b), .Blue(b_b)
  );

  logic [7:0] rom [2048];

  always @(posedge Clk) begin
    fd_a <= rom[fa_a];
    fd_b <= rom[fa_b];
  end

  logic [7:0] mchr  [2][N];
  logic [2:0] mattr [2][N];
  int mact, mpend, nfs;
  int nvec, nerr;

  function automatic logic [23:0] pal(input logic [1:0] i);
    case (i)
      2'd0: return 24'hFFFF00;
      2'd1: return 24'hFFFFFF;
      2'd2: return 24'hFF0000;
      default: return 24'h00FFFF;
    endcase
  endfunction

  function automatic bit blink_off();
`ifdef TEXT_OVERLAY_BLINK_EN
    return ((nfs / BF) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected {font_addr, text_on, rgb} for a pixel under the current model state.
  function automatic logic [35:0] model_px(input int sl, input int pitch,
                                           input int x, input int y);
    int s, sx, row, col;
    logic [7:0] c, gl;
    logic [2:0] a;
    logic [10:0] fa;
    logic [24:0] px;
    s = 1 << sl;
    fa = '0;
    px = '0;
    for (int i = 0; i < N; i++) begin
      sx = OX + i * pitch;
      if (x >= sx && x < sx + 8 * s && y >= OY && y < OY + 16 * s) begin
        c = mchr[mact][i];
        a = mattr[mact][i];
        row = (y - OY) / s;
        col = (x - sx) / s;
        fa = {c[6:0], 4'(row)};
        gl = rom[fa];
        if (c != 0 && gl[7-col] && !(a[2] && blink_off()))
          px = {1'b1, pal(a[1:0])};
      end
    end
    return {fa, px};
  endfunction

  task automatic step();
    @(posedge Clk);
    if (!Reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++) begin
          mchr[b][i] = '0;
          mattr[b][i] = '0;
        end
      mact = 0;
      mpend = 0;
      nfs = 0;
    end else begin
      if (wr_en && wr_addr < N) begin
        mchr[1-mact][wr_addr] = wr_char;
        mattr[1-mact][wr_addr] = wr_attr;
      end
      if (frame_start && mpend == 1) begin
        mact = 1 - mact;
        mpend = 0;
      end else if (swap_req) begin
        mpend = 1;
      end
      if (frame_start) nfs++;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 0;
    swap_req = 0;
    frame_start = 0;
    DrawX = 0;
    DrawY = 0;
  endtask

  task automatic write(input int a, input int c, input int at,
                       input bit sw);
    wr_en = 1;
    wr_addr = 4'(a);
    wr_char = 8'(c);
    wr_attr = 3'(at);
    swap_req = sw;
    step();
    idle();
  endtask

  task automatic fs(input bit sw);
    frame_start = 1;
    swap_req = sw;
    step();
    idle();
  endtask

  // Presents one pixel and returns each instance's {font_addr, text_on, rgb}.
  task automatic probe(input int x, input int y,
                       output logic [35:0] oa, output logic [35:0] ob);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
    oa[35:25] = fa_a;
    ob[35:25] = fa_b;
    DrawX = 0;
    DrawY = 0;
    step();
    step();
    oa[24:0] = {on_a, r_a, g_a, b_a};
    ob[24:0] = {on_b, r_b, g_b, b_b};
  endtask

  task automatic test_reset();
    Reset = 0;
    idle();
    step();
    step();
    nvec += 4;
    if (so_a !== 1'b0 || so_b !== 1'b0) begin
      nerr++;
      $display("FAIL reset_pending: got %b%b want 00", so_a, so_b);
    end
    if (fa_a !== 11'd0 || fa_b !== 11'd0) begin
      nerr++;
      $display("FAIL reset_faddr: got %h %h want 0", fa_a, fa_b);
    end
    if (on_a !== 1'b0 || on_b !== 1'b0) begin
      nerr++;
      $display("FAIL reset_text_on: got %b %b want 0", on_a, on_b);
    end
    if ({r_a, g_a, b_a, r_b, g_b, b_b} !== 48'd0) begin
      nerr++;
      $display("FAIL reset_rgb: got %h%h%h want 0", r_a, g_a, b_a);
    end
    Reset = 1;
    step();
  endtask

  task automatic test_basic();
    logic [35:0] oa, ob, ea, eb;
    write(0, 8'h4C, 0, 1);
    nvec++;
    if (so_a !== 1'(mpend) || so_a !== 1'b1) begin
      nerr++;
      $display("FAIL basic_pending: got %b want 1", so_a);
    end
    fs(0);
    nvec++;
    if (so_a !== 1'b0) begin
      nerr++;
      $display("FAIL basic_swapped: got %b want 0", so_a);
    end
    ea = model_px(0, PA, 230, 80);
    eb = model_px(1, PB, 230, 80);
    probe(230, 80, oa, ob);
    nvec += 3;
    if (oa !== {11'h4C0, 1'b1, 24'hFFFF00} || oa !== ea) begin
      nerr++;
      $display("FAIL basic_L_lit: got %h want %h", oa, ea);
    end
    if (ob !== eb) begin
      nerr++;
      $display("FAIL basic_L_lit_x2: got %h want %h", ob, eb);
    end
    ea = model_px(0, PA, 232, 80);
    eb = model_px(1, PB, 232, 80);
    probe(232, 80, oa, ob);
    if (oa[24:0] !== 25'd0 || oa !== ea) begin
      nerr++;
      $display("FAIL basic_L_dark: got %h want %h", oa, ea);
    end
    nvec++;
    if (ob !== eb) begin
      nerr++;
      $display("FAIL basic_L_col1_x2: got %h want %h", ob, eb);
    end
  endtask

  task automatic test_noswap();
    logic [35:0] oa, ob, ea, eb;
    write(1, 8'h41, 2, 0);
    for (int f = 0; f < 3; f++) begin
      fs(0);
      step();
    end
    nvec++;
    if (so_a !== 1'b0 || so_b !== 1'b0) begin
      nerr++;
      $display("FAIL noswap_pending: got %b%b want 00", so_a, so_b);
    end
    ea = model_px(0, PA, 240, 80);
    eb = model_px(1, PB, 240, 80);
    probe(240, 80, oa, ob);
    nvec += 2;
    if (oa[24:0] !== 25'd0 || oa !== ea) begin
      nerr++;
      $display("FAIL noswap_hidden: got %h want %h", oa, ea);
    end
    if (ob !== eb) begin
      nerr++;
      $display("FAIL noswap_hidden_x2: got %h want %h", ob, eb);
    end
    write(5, 0, 0, 1);
    fs(0);
    ea = model_px(0, PA, 240, 80);
    probe(240, 80, oa, ob);
    nvec++;
    if (oa !== {11'h410, 1'b1, 24'hFF0000} || oa !== ea) begin
      nerr++;
      $display("FAIL noswap_red: got %h want %h", oa, ea);
    end
  endtask

  task automatic test_swap_coincident();
    logic [35:0] oa, ob, ea, eb;
    fs(1);
    nvec++;
    if (so_a !== 1'b1 || mact != 0) begin
      nerr++;
      $display("FAIL coinc_pending: got %b want 1", so_a);
    end
    ea = model_px(0, PA, 240, 80);
    probe(240, 80, oa, ob);
    nvec++;
    if (oa[24] !== 1'b1 || oa !== ea) begin
      nerr++;
      $display("FAIL coinc_no_toggle: got %h want %h", oa, ea);
    end
    fs(0);
    nvec++;
    if (so_a !== 1'b0) begin
      nerr++;
      $display("FAIL coinc_cleared: got %b want 0", so_a);
    end
    ea = model_px(0, PA, 240, 80);
    eb = model_px(1, PB, 230, 80);
    probe(240, 80, oa, ob);
    nvec++;
    if (oa[24] !== 1'b0 || oa !== ea) begin
      nerr++;
      $display("FAIL coinc_toggled: got %h want %h", oa, ea);
    end
    probe(230, 80, oa, ob);
    nvec++;
    if (ob !== eb) begin
      nerr++;
      $display("FAIL coinc_toggled_x2: got %h want %h", ob, eb);
    end
  endtask

  task automatic test_write_on_swap();
    logic [35:0] oa, ob, ea;
    write(6, 0, 0, 1);
    wr_en = 1;
    wr_addr = 2;
    wr_char = 8'h4C;
    wr_attr = 3;
    frame_start = 1;
    step();
    idle();
    ea = model_px(0, PA, 250, 80);
    probe(250, 80, oa, ob);
    nvec++;
    if (oa !== {11'h4C0, 1'b1, 24'h00FFFF} || oa !== ea) begin
      nerr++;
      $display("FAIL wr_on_swap: got %h want %h", oa, ea);
    end
  endtask

  task automatic test_scale();
    logic [35:0] oa, ob, ea, eb;
    int xs[4] = '{231, 233, 233, 231};
    int ys[4] = '{81, 81, 111, 112};
    logic [35:0] want[4];
    rom[11'h520] = 8'h80;
    rom[11'h52F] = 8'hC0;
    want[0] = {11'h520, 1'b1, 24'hFFFFFF};
    want[1] = {11'h520, 25'd0};
    want[2] = {11'h52F, 1'b1, 24'hFFFFFF};
    want[3] = 36'd0;
    write(0, 8'h52, 1, 1);
    fs(0);
    for (int k = 0; k < 4; k++) begin
      ea = model_px(0, PA, xs[k], ys[k]);
      eb = model_px(1, PB, xs[k], ys[k]);
      probe(xs[k], ys[k], oa, ob);
      nvec += 2;
      if (ob !== want[k] || ob !== eb) begin
        nerr++;
        $display("FAIL scale_x2_%0d: got %h want %h", k, ob, want[k]);
      end
      if (oa !== ea) begin
        nerr++;
        $display("FAIL scale_x1_%0d: got %h want %h", k, oa, ea);
      end
    end
  endtask

  task automatic test_blink();
    logic [35:0] oa, ob, ea;
    rom[11'h420] = 8'hFF;
    write(3, 8'h42, 3'b100, 1);
    for (int f = 0; f < 6; f++) begin
      fs(0);
      ea = model_px(0, PA, 260, 80);
      probe(260, 80, oa, ob);
      nvec++;
      if (oa !== ea) begin
        nerr++;
        $display("FAIL blink_f%0d: got %h want %h", nfs, oa, ea);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] ea[NS], eb[NS];
    int c;
    for (int k = 0; k < 40; k++) begin
      c = $urandom_range(1, 255);
      if (c == 8'h80) c = 8'h81;
      if ($urandom % 8 == 0) c = 0;
      wr_en = 1'($urandom);
      wr_addr = 4'($urandom);
      wr_char = 8'(c);
      wr_attr = 3'($urandom);
      swap_req = ($urandom % 4 == 0);
      frame_start = ($urandom % 5 == 0);
      step();
      nvec++;
      if (so_a !== 1'(mpend) || so_b !== 1'(mpend)) begin
        nerr++;
        $display("FAIL rnd_pending_%0d: got %b%b want %0d", k, so_a, so_b, mpend);
      end
    end
    idle();
    for (int k = 0; k < NS + 2; k++) begin
      if (k < NS) begin
        DrawX = 10'($urandom_range(226, 560));
        DrawY = 10'($urandom_range(76, 115));
        ea[k] = model_px(0, PA, int'(DrawX), int'(DrawY));
        eb[k] = model_px(1, PB, int'(DrawX), int'(DrawY));
      end else begin
        DrawX = 0;
        DrawY = 0;
      end
      step();
      if (k < NS) begin
        nvec++;
        if ({fa_a, fa_b} !== {ea[k][35:25], eb[k][35:25]}) begin
          nerr++;
          $display("FAIL stream_faddr_%0d: got %h %h want %h %h",
                   k, fa_a, fa_b, ea[k][35:25], eb[k][35:25]);
        end
      end
      if (k >= 2) begin
        nvec++;
        if ({on_a, r_a, g_a, b_a} !== ea[k-2][24:0] ||
            {on_b, r_b, g_b, b_b} !== eb[k-2][24:0]) begin
          nerr++;
          $display("FAIL stream_px_%0d: got %b%h%h%h %b%h%h%h want %h %h",
                   k - 2, on_a, r_a, g_a, b_a, on_b, r_b, g_b, b_b,
                   ea[k-2][24:0], eb[k-2][24:0]);
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [35:0] oa, ob, ea;
    write(0, 8'h4C, 0, 1);
    fs(0);
    write(7, 0, 0, 1);
    DrawX = 230;
    DrawY = 80;
    step();
    step();
    step();
    nvec++;
    if (on_a !== 1'b1) begin
      nerr++;
      $display("FAIL rstmid_pre: got %b want 1", on_a);
    end
    Reset = 0;
    step();
    nvec++;
    if ({on_a, r_a, g_a, b_a, so_a, fa_a} !== 37'd0) begin
      nerr++;
      $display("FAIL rstmid_clear: got %b %h%h%h %b %h want 0",
               on_a, r_a, g_a, b_a, so_a, fa_a);
    end
    Reset = 1;
    idle();
    step();
    fs(1);
    fs(0);
    ea = model_px(0, PA, 230, 80);
    probe(230, 80, oa, ob);
    nvec++;
    if (oa !== 36'd0 || oa !== ea) begin
      nerr++;
      $display("FAIL rstmid_gone: got %h want %h", oa, ea);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    mact = 0;
    mpend = 0;
    nfs = 0;
    wr_addr = 0;
    wr_char = 0;
    wr_attr = 0;
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[11'h4C0] = 8'hC0;
    rom[11'h410] = 8'hFF;
    test_reset();
    test_basic();
    test_noswap();
    test_swap_coincident();
    test_write_on_swap();
    test_scale();
    test_back_to_back();
    Reset = 0;
    step();
    Reset = 1;
    test_blink();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
